dram_seq: RTL

Single-bank page-mode DRAM cycle sequencer. It accepts one read/write request at a time and drives RAS/CAS/WE and the multiplexed address. It consults the external open-row comparator (match) to choose between a page-hit column cycle and a full precharge/activate cycle, and it schedules CAS-before-RAS refresh. It sits between the memory-interface request logic and the DRAM pins, one instance per bank, and drives the row comparator's load strobe.

---
 rtl/dram_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dram_seq.sv
// Single-bank page-mode DRAM cycle sequencer: drives RAS/CAS/WE and the muxed
// address, chooses page-hit or precharge/activate cycles, and schedules CBR refresh.
module dram_seq #(
  parameter int unsigned ROW_W   = 11,
  parameter int unsigned COL_W   = 10,
  parameter int unsigned TRP     = 2,
  parameter int unsigned TRCD    = 2,
  parameter int unsigned TCAS    = 2,
  parameter int unsigned REF_INT = 256
) (
  input  logic                   sys_clk,
  input  logic                   resl,
  input  logic                   req,
  input  logic                   we,
  input  logic [ROW_W+COL_W-1:0] addr,
  output logic                   ack,
  output logic                   busy,
  output logic                   ras_n,
  output logic                   cas_n,
  output logic                   we_n,
  output logic [ROW_W-1:0]       ma,
  output logic [ROW_W-1:0]       row_a,
  output logic                   newrow,
  input  logic                   match
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_CAS, S_DONE, S_REF} state_t;
  // What a precharge leads into: a request's ACT, a refresh, or back to IDLE.
  typedef enum logic [1:0] {P_REQ, P_REF, P_POST} pre_t;

  localparam int unsigned D1    = (TRP > TRCD) ? TRP : TRCD;
  localparam int unsigned D2    = (D1 > TCAS) ? D1 : TCAS;
  localparam int unsigned DMAX  = (D2 > 4) ? D2 : 4;
  localparam int unsigned CNT_W = $clog2(DMAX);
  localparam int unsigned RF_W  = $clog2(REF_INT);

  state_t             r_state, w_next;
  pre_t               r_pre_kind, w_pre_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [RF_W-1:0]    r_ref_cnt;
  logic               r_row_open, r_ref_pend;
  logic [ROW_W-1:0]   r_ma;
  logic               w_last, w_hit;
  logic [COL_W-1:0]   w_col;

  assign row_a = addr[ROW_W+COL_W-1:COL_W];
  assign w_col = addr[COL_W-1:0];
  assign w_hit = match & r_row_open;
  assign busy  = (r_state != S_IDLE);

  always_comb begin
    unique case (r_state)
      S_PRE:   w_last = (r_cnt == CNT_W'(TRP - 1));
      S_ACT:   w_last = (r_cnt == CNT_W'(TRCD - 1));
      S_CAS:   w_last = (r_cnt == CNT_W'(TCAS - 1));
      S_REF:   w_last = (r_cnt == CNT_W'(3));
      default: w_last = 1'b1;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_pre_next = r_pre_kind;
    ras_n      = 1'b1;
    cas_n      = 1'b1;
    we_n       = 1'b1;
    ack        = 1'b0;
    newrow     = 1'b0;
    ma         = r_ma;
    unique case (r_state)
      S_IDLE: begin
        ras_n = ~r_row_open;
        if (r_ref_pend) begin
          if (r_row_open) begin
            w_next     = S_PRE;
            w_pre_next = P_REF;
          end else begin
            w_next = S_REF;
          end
        end else if (req) begin
          if (w_hit) begin
            w_next = S_CAS;
          end else if (r_row_open) begin
            w_next     = S_PRE;
            w_pre_next = P_REQ;
          end else begin
            w_next = S_ACT;
          end
        end
      end
      S_PRE: begin
        if (w_last) begin
          unique case (r_pre_kind)
            P_REF:   w_next = S_REF;
            P_REQ:   w_next = S_ACT;
            default: w_next = S_IDLE;
          endcase
        end
      end
      S_ACT: begin
        ras_n  = 1'b0;
        ma     = row_a;
        newrow = (r_cnt == '0);
        if (w_last) w_next = S_CAS;
      end
      S_CAS: begin
        ras_n = 1'b0;
        cas_n = 1'b0;
        we_n  = ~we;
        ma    = ROW_W'(w_col);
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        ras_n  = 1'b0;
        ack    = 1'b1;
        w_next = S_IDLE;
      end
      S_REF: begin
        // CAS-before-RAS: CAS leads RAS by one cycle.
        cas_n = 1'b0;
        ras_n = (r_cnt == '0);
        if (w_last) begin
          w_next     = S_PRE;
          w_pre_next = P_POST;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resl) begin
      r_state    <= S_IDLE;
      r_pre_kind <= P_REQ;
      r_cnt      <= '0;
      r_row_open <= 1'b0;
      r_ref_pend <= 1'b0;
      r_ref_cnt  <= RF_W'(REF_INT - 1);
      r_ma       <= '0;
    end else begin
      r_state    <= w_next;
      r_pre_kind <= w_pre_next;
      r_ma       <= ma;
      if (w_next != r_state || r_state == S_IDLE) r_cnt <= '0;
      else                                        r_cnt <= r_cnt + CNT_W'(1);
      if (w_next == S_ACT && r_state != S_ACT) r_row_open <= 1'b1;
      else if (r_state == S_PRE)               r_row_open <= 1'b0;
      // An expiry coinciding with REF entry must survive the clear.
      if (r_ref_cnt == '0)                          r_ref_pend <= 1'b1;
      else if (w_next == S_REF && r_state != S_REF) r_ref_pend <= 1'b0;
      if (r_ref_cnt == '0) r_ref_cnt <= RF_W'(REF_INT - 1);
      else                 r_ref_cnt <= r_ref_cnt - RF_W'(1);
    end
  end

endmodule
